// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle, signed/unsigned with sign fix-up.
// Optional SEQ_DIVIDER_ZERO_FAST_EN: zero divisor short-circuits to a zero result in one cycle.
module seq_divider #(
    parameter int unsigned DIV_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     signed_div_i,
    input  logic [DIV_WIDTH-1:0]     opdata1_i,
    input  logic [DIV_WIDTH-1:0]     opdata2_i,
    input  logic                     start_i,
    input  logic                     annul_i,
    output logic [2*DIV_WIDTH-1:0]   result_o,
    output logic                     ready_o
);

    localparam int unsigned CntW = $clog2(DIV_WIDTH + 1);

`ifdef SEQ_DIVIDER_ZERO_FAST_EN
    typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_t;
`else
    typedef enum logic [1:0] {StIdle, StOn, StEnd} state_t;
`endif

    state_t                 r_state, w_state_d;
    logic [CntW-1:0]        r_cnt, w_cnt_d;
    logic                   r_signed, w_signed_d;
    logic                   r_neg1, w_neg1_d;
    logic                   r_neg2, w_neg2_d;
    logic [DIV_WIDTH-1:0]   r_divisor, w_divisor_d;
    logic [DIV_WIDTH-1:0]   r_rem, w_rem_d;
    logic [DIV_WIDTH-1:0]   r_quo, w_quo_d;
    logic [2*DIV_WIDTH-1:0] r_result, w_result_d;
    logic                   r_ready, w_ready_d;

    logic                   w_op1_neg, w_op2_neg;
    logic [DIV_WIDTH-1:0]   w_op1_abs, w_op2_abs;
    logic [DIV_WIDTH:0]     w_trial, w_diff;
    logic                   w_ge;
    logic [DIV_WIDTH-1:0]   w_quo_fix, w_rem_fix;

    assign w_op1_neg = signed_div_i & opdata1_i[DIV_WIDTH-1];
    assign w_op2_neg = signed_div_i & opdata2_i[DIV_WIDTH-1];
    assign w_op1_abs = w_op1_neg ? -opdata1_i : opdata1_i;
    assign w_op2_abs = w_op2_neg ? -opdata2_i : opdata2_i;

    // Trial < 2*divisor, so bit DIV_WIDTH of the difference is exactly the borrow.
    assign w_trial = {r_rem, r_quo[DIV_WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_divisor};
    assign w_ge    = ~w_diff[DIV_WIDTH];

    assign w_quo_fix = (r_signed && (r_neg1 != r_neg2)) ? -r_quo : r_quo;
    assign w_rem_fix = (r_signed && r_neg1) ? -r_rem : r_rem;

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_signed_d  = r_signed;
        w_neg1_d    = r_neg1;
        w_neg2_d    = r_neg2;
        w_divisor_d = r_divisor;
        w_rem_d     = r_rem;
        w_quo_d     = r_quo;
        w_result_d  = r_result;
        w_ready_d   = r_ready;

        unique case (r_state)
            StIdle: begin
                if (start_i && !annul_i) begin
                    w_signed_d  = signed_div_i;
                    w_neg1_d    = w_op1_neg;
                    w_neg2_d    = w_op2_neg;
                    w_divisor_d = w_op2_abs;
                    w_quo_d     = w_op1_abs;
                    w_rem_d     = '0;
                    w_cnt_d     = '0;
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
                    w_state_d   = (opdata2_i == '0) ? StByZero : StOn;
`else
                    w_state_d   = StOn;
`endif
                end
            end
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
            StByZero: begin
                if (annul_i || !start_i) begin
                    w_state_d  = StIdle;
                    w_ready_d  = 1'b0;
                    w_result_d = '0;
                end else begin
                    w_state_d  = StEnd;
                    w_ready_d  = 1'b1;
                    w_result_d = '0;
                end
            end
`endif
            StOn: begin
                if (annul_i || !start_i) begin
                    w_state_d  = StIdle;
                    w_ready_d  = 1'b0;
                    w_result_d = '0;
                end else if (r_cnt == CntW'(DIV_WIDTH)) begin
                    w_state_d  = StEnd;
                    w_ready_d  = 1'b1;
                    w_result_d = {w_rem_fix, w_quo_fix};
                end else begin
                    w_rem_d = w_ge ? w_diff[DIV_WIDTH-1:0] : w_trial[DIV_WIDTH-1:0];
                    w_quo_d = {r_quo[DIV_WIDTH-2:0], w_ge};
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            StEnd: begin
                if (!start_i) begin
                    w_state_d  = StIdle;
                    w_ready_d  = 1'b0;
                    w_result_d = '0;
                end
            end
            default: begin
                w_state_d  = StIdle;
                w_ready_d  = 1'b0;
                w_result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_signed  <= 1'b0;
            r_neg1    <= 1'b0;
            r_neg2    <= 1'b0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_signed  <= w_signed_d;
            r_neg1    <= w_neg1_d;
            r_neg2    <= w_neg2_d;
            r_divisor <= w_divisor_d;
            r_rem     <= w_rem_d;
            r_quo     <= w_quo_d;
            r_result  <= w_result_d;
            r_ready   <= w_ready_d;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule
